// File: rtl/dda_sequencer_if.sv
// Byte-stream interface of the DDA sequencer: a command stream into the
// sequencer (rx_*) and a result stream out of it (tx_*).
//
// Handshake: a byte transfers on every rising clock edge where valid and
// ready are both high. The sender holds valid and data stable until that edge.
// The receiver may raise or drop ready at any time.
//
// Modport master is the host side (it sends commands and sinks results).
// Modport slave is the sequencer side.
interface dda_sequencer_if;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;

    modport master (
        output rx_valid,
        output rx_data,
        input  rx_ready,
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        output rx_ready,
        output tx_valid,
        output tx_data,
        input  tx_ready
    );
endinterface

// File: rtl/dda_sequencer.sv
// DDA sequencer: decodes a byte command stream, manages the DDA parameter
// registers, runs the DDA for a requested number of steps, and streams a
// snapshot of {x, y} back as four bytes (x MSB first, then y MSB first).
//
// Command bytes accepted in IDLE:
//   0x10..0x13 + 2 argument bytes : write icx/icy/mu/dt (low two opcode bits)
//   0x20 + 2 argument bytes       : run that many DDA steps, then snapshot
//   0x30                          : one-cycle dda_load pulse
//   0x40                          : snapshot immediately
//   0x50 (DDA_SEQ_FREERUN_EN only): toggle free-run mode
// Every other byte is discarded.
//
// Optional feature macro: DDA_SEQ_FREERUN_EN. When it is defined, free-run
// mode keeps dda_en high in IDLE and streams snapshots back to back whenever
// no command byte is waiting.
//
// Every output is a flop. Each output's next value is derived from the next
// state, so the outputs line up with the state register cycle for cycle.
module dda_sequencer #(
    parameter int N  = 16,
    parameter int CW = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    dda_sequencer_if.slave       bus,
    input  logic [N-1:0]         x,
    input  logic [N-1:0]         y,
    output logic [N-1:0]         icx,
    output logic [N-1:0]         icy,
    output logic [N-1:0]         mu,
    output logic [N-1:0]         dt,
    output logic                 dda_en,
    output logic                 dda_load,
    output logic                 busy
);

    localparam logic [N-1:0] ICX_RST = N'(16'hC000);
    localparam logic [N-1:0] ICY_RST = N'(16'h14CD);
    localparam logic [N-1:0] MU_RST  = N'(16'h14DD);
    localparam logic [N-1:0] DT_RST  = N'(16'h7240);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ARG_HI  = 3'd1,
        S_ARG_LO  = 3'd2,
        S_RUN     = 3'd3,
        S_CAPTURE = 3'd4,
        S_SEND    = 3'd5
    } state_t;

    // Registered state
    state_t         state_q,    state_d;
    logic           cmd_run_q,  cmd_run_d;   // 1: run command, 0: parameter write
    logic [1:0]     par_sel_q,  par_sel_d;   // parameter selected by a write
    logic [7:0]     arg_hi_q,   arg_hi_d;    // MSB byte of the argument
    logic [CW-1:0]  cnt_q,      cnt_d;       // DDA steps still to issue
    logic [31:0]    snap_q,     snap_d;      // {x[15:0], y[15:0]} snapshot
    logic [1:0]     idx_q,      idx_d;       // snapshot byte being sent
    logic [N-1:0]   icx_q,      icx_d;
    logic [N-1:0]   icy_q,      icy_d;
    logic [N-1:0]   mu_q,       mu_d;
    logic [N-1:0]   dt_q,       dt_d;

    // Registered outputs
    logic           rx_ready_q, rx_ready_d;
    logic           tx_valid_q, tx_valid_d;
    logic [7:0]     tx_data_q,  tx_data_d;
    logic           dda_en_q,   dda_en_d;
    logic           dda_load_q, dda_load_d;
    logic           busy_q,     busy_d;

`ifdef DDA_SEQ_FREERUN_EN
    logic           freerun_q,  freerun_d;
`endif

    logic           rx_fire;
    logic           tx_fire;
    logic [15:0]    arg;

    assign rx_fire = bus.rx_valid & rx_ready_q;
    assign tx_fire = tx_valid_q & bus.tx_ready;
    assign arg     = {arg_hi_q, bus.rx_data};

    // The snapshot goes out MSB first: x high, x low, y high, y low.
    function automatic logic [7:0] snap_byte(input logic [31:0] s, input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = s[31:24];
            2'd1:    b = s[23:16];
            2'd2:    b = s[15:8];
            default: b = s[7:0];
        endcase
        return b;
    endfunction

    // Next-state and next-output logic for the command/run/send sequence
    always_comb begin
        state_d    = state_q;
        cmd_run_d  = cmd_run_q;
        par_sel_d  = par_sel_q;
        arg_hi_d   = arg_hi_q;
        cnt_d      = cnt_q;
        snap_d     = snap_q;
        idx_d      = idx_q;
        icx_d      = icx_q;
        icy_d      = icy_q;
        mu_d       = mu_q;
        dt_d       = dt_q;
        dda_load_d = 1'b0;
`ifdef DDA_SEQ_FREERUN_EN
        freerun_d  = freerun_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (rx_fire) begin
                    casez (bus.rx_data)
                        8'b0001_00??: begin
                            cmd_run_d = 1'b0;
                            par_sel_d = bus.rx_data[1:0];
                            state_d   = S_ARG_HI;
                        end
                        8'h20: begin
                            cmd_run_d = 1'b1;
                            state_d   = S_ARG_HI;
                        end
                        8'h30: dda_load_d = 1'b1;
                        8'h40: state_d    = S_CAPTURE;
`ifdef DDA_SEQ_FREERUN_EN
                        8'h50: freerun_d  = ~freerun_q;
`endif
                        default: ;
                    endcase
                end
`ifdef DDA_SEQ_FREERUN_EN
                // rx_ready is high in IDLE, so no fire means no byte waiting.
                else if (freerun_q) begin
                    state_d = S_CAPTURE;
                end
`endif
            end

            S_ARG_HI: begin
                if (rx_fire) begin
                    arg_hi_d = bus.rx_data;
                    state_d  = S_ARG_LO;
                end
            end

            S_ARG_LO: begin
                if (rx_fire) begin
                    if (cmd_run_q) begin
                        cnt_d   = CW'(arg);
                        state_d = (arg != 16'h0000) ? S_RUN : S_CAPTURE;
                    end else begin
                        case (par_sel_q)
                            2'd0:    icx_d = N'(arg);
                            2'd1:    icy_d = N'(arg);
                            2'd2:    mu_d  = N'(arg);
                            default: dt_d  = N'(arg);
                        endcase
                        state_d = S_IDLE;
                    end
                end
            end

            S_RUN: begin
                // One DDA step per cycle. The cycle that sees a count of 1
                // is the last step.
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = S_CAPTURE;
                end
            end

            S_CAPTURE: begin
                snap_d  = {x[15:0], y[15:0]};
                idx_d   = 2'd0;
                state_d = S_SEND;
            end

            S_SEND: begin
                if (tx_fire) begin
                    if (idx_q == 2'd3) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            default: state_d = S_IDLE;
        endcase

        rx_ready_d = (state_d == S_IDLE) || (state_d == S_ARG_HI) || (state_d == S_ARG_LO);
        busy_d     = (state_d != S_IDLE);
        tx_valid_d = (state_d == S_SEND);
        tx_data_d  = (state_d == S_SEND) ? snap_byte(snap_d, idx_d) : 8'h00;
`ifdef DDA_SEQ_FREERUN_EN
        dda_en_d   = (state_d == S_RUN) || (freerun_d && (state_d == S_IDLE));
`else
        dda_en_d   = (state_d == S_RUN);
`endif
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cmd_run_q  <= 1'b0;
            par_sel_q  <= 2'd0;
            arg_hi_q   <= 8'h00;
            cnt_q      <= '0;
            snap_q     <= 32'h0;
            idx_q      <= 2'd0;
            icx_q      <= ICX_RST;
            icy_q      <= ICY_RST;
            mu_q       <= MU_RST;
            dt_q       <= DT_RST;
            rx_ready_q <= 1'b1;
            tx_valid_q <= 1'b0;
            tx_data_q  <= 8'h00;
            dda_en_q   <= 1'b0;
            dda_load_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef DDA_SEQ_FREERUN_EN
            freerun_q  <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cmd_run_q  <= cmd_run_d;
            par_sel_q  <= par_sel_d;
            arg_hi_q   <= arg_hi_d;
            cnt_q      <= cnt_d;
            snap_q     <= snap_d;
            idx_q      <= idx_d;
            icx_q      <= icx_d;
            icy_q      <= icy_d;
            mu_q       <= mu_d;
            dt_q       <= dt_d;
            rx_ready_q <= rx_ready_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            dda_en_q   <= dda_en_d;
            dda_load_q <= dda_load_d;
            busy_q     <= busy_d;
`ifdef DDA_SEQ_FREERUN_EN
            freerun_q  <= freerun_d;
`endif
        end
    end

    assign bus.rx_ready = rx_ready_q;
    assign bus.tx_valid = tx_valid_q;
    assign bus.tx_data  = tx_data_q;
    assign icx          = icx_q;
    assign icy          = icy_q;
    assign mu           = mu_q;
    assign dt           = dt_q;
    assign dda_en       = dda_en_q;
    assign dda_load     = dda_load_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_dda_sequencer.sv
// Testbench for dda_sequencer. It applies directed command sequences, then
// randomized writes, runs and junk bytes. Results are checked against a small
// reference model: parameter values, expected step counts and expected
// snapshot bytes.
module tb_dda_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] x, y;
    logic [15:0] icx, icy, mu, dt;
    logic        dda_en, dda_load, busy;

    always #5 clk = ~clk;

    dda_sequencer_if bus();

    dda_sequencer #(.N(16), .CW(16)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .x        (x),
        .y        (y),
        .icx      (icx),
        .icy      (icy),
        .mu       (mu),
        .dt       (dt),
        .dda_en   (dda_en),
        .dda_load (dda_load),
        .busy     (busy)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          en_cnt   = 0;
    int          load_cnt = 0;
    int          busy_cnt = 0;
    logic        rand_ready  = 1'b0;
    logic        ready_fixed = 1'b1;
    logic [15:0] model_par[4];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Result-side ready: either a fixed level or a random level each cycle.
    always @(posedge clk) begin
        #1;
        bus.tx_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fixed;
    end

    // Monitor: counts strobes, records transferred bytes, and checks that a
    // stalled result byte is held.
    logic       stall_prev = 1'b0;
    logic [7:0] stall_data = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 1'b0;
        end else begin
            if (dda_en)   en_cnt++;
            if (dda_load) load_cnt++;
            if (busy)     busy_cnt++;
            if (stall_prev) begin
                check("tx_hold_valid", {31'd0, bus.tx_valid}, 32'd1);
                check("tx_hold_data", {24'd0, bus.tx_data}, {24'd0, stall_data});
            end
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_data);
            stall_prev = bus.tx_valid && !bus.tx_ready;
            stall_data = bus.tx_data;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(posedge clk); #1;
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        forever begin
            @(negedge clk);
            if (bus.rx_ready) break;
            n++;
            if (n > 300) begin
                check("rx_accept_timeout", 32'd0, 32'd1);
                bus.rx_valid = 1'b0;
                return;
            end
        end
        @(posedge clk); #1;
        bus.rx_valid = 1'b0;
    endtask

    task automatic wait_idle(input int max_cycles);
        int n;
        n = 0;
        forever begin
            @(negedge clk); #1;
            if (!busy) break;
            n++;
            if (n > max_cycles) begin
                check("idle_timeout", 32'd0, 32'd1);
                return;
            end
        end
    endtask

    task automatic clear_counts();
        en_cnt   = 0;
        load_cnt = 0;
        busy_cnt = 0;
        got_q.delete();
    endtask

    // Reference snapshot: x then y, each most significant byte first.
    task automatic expect_snapshot();
        exp_q.delete();
        exp_q.push_back(8'((x / 256) % 256));
        exp_q.push_back(8'(x % 256));
        exp_q.push_back(8'((y / 256) % 256));
        exp_q.push_back(8'(y % 256));
    endtask

    task automatic compare_bytes(input string tag);
        check({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            check({tag, "_byte"}, {24'd0, got_q[i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic check_params(input string tag);
        check({tag, "_icx"}, {16'd0, icx}, {16'd0, model_par[0]});
        check({tag, "_icy"}, {16'd0, icy}, {16'd0, model_par[1]});
        check({tag, "_mu"},  {16'd0, mu},  {16'd0, model_par[2]});
        check({tag, "_dt"},  {16'd0, dt},  {16'd0, model_par[3]});
    endtask

    task automatic reset_model();
        model_par[0] = 16'hC000;
        model_par[1] = 16'h14CD;
        model_par[2] = 16'h14DD;
        model_par[3] = 16'h7240;
    endtask

    task automatic do_run(input string tag, input logic [15:0] steps);
        clear_counts();
        send_byte(8'h20);
        send_byte(steps[15:8]);
        send_byte(steps[7:0]);
        wait_idle(int'(steps) + 600);
        expect_snapshot();
        check({tag, "_steps"}, en_cnt, {16'd0, steps});
        compare_bytes(tag);
    endtask

    task automatic do_write(input logic [1:0] k, input logic [15:0] v);
        send_byte(8'h10 | {6'd0, k});
        send_byte(v[15:8]);
        send_byte(v[7:0]);
        model_par[k] = v;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog expired before the bench finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  first_byte;
        logic [15:0] steps;
        logic [7:0]  junk;
        int          n;

        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        bus.tx_ready = 1'b1;
        x = 16'h0000;
        y = 16'h0000;
        reset_model();

        // Reset values while rst is held
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_dda_en",   {31'd0, dda_en}, 32'd0);
        check("rst_dda_load", {31'd0, dda_load}, 32'd0);
        check("rst_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("rst_tx_data",  {24'd0, bus.tx_data}, 32'd0);
        check("rst_busy",     {31'd0, busy}, 32'd0);
        check_params("rst");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        // Write dt
        send_byte(8'h13);
        send_byte(8'h12);
        send_byte(8'h34);
        model_par[3] = 16'h1234;
        @(negedge clk);
        check_params("write_dt");

        // Five-step run with fixed x/y
        x = 16'hABCD;
        y = 16'h0102;
        do_run("run5", 16'd5);

        // Zero-step run gives an immediate snapshot
        x = 16'h5A5A;
        y = 16'hC3C3;
        do_run("run0", 16'd0);

        // Stall the result stream for 10 cycles
        ready_fixed = 1'b0;
        x = 16'h1357;
        y = 16'h2468;
        clear_counts();
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h02);
        n = 0;
        while (!bus.tx_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("stall_tx_valid_seen", {31'd0, bus.tx_valid}, 32'd1);
        expect_snapshot();
        first_byte = exp_q[0];
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_valid",    {31'd0, bus.tx_valid}, 32'd1);
            check("stall_data",     {24'd0, bus.tx_data}, {24'd0, first_byte});
            check("stall_rx_ready", {31'd0, bus.rx_ready}, 32'd0);
        end
        ready_fixed = 1'b1;
        wait_idle(100);
        check("stall_steps", en_cnt, 32'd2);
        compare_bytes("stall");

        // Load pulse, followed by an ignored byte
        clear_counts();
        send_byte(8'h30);
        send_byte(8'h7F);
        repeat (4) @(negedge clk);
        check("load_pulses", load_cnt, 32'd1);
        check("load_busy",   busy_cnt, 32'd0);
        check("load_no_tx",  got_q.size(), 32'd0);
        check_params("load");

        // Immediate capture command
        x = 16'hFEDC;
        y = 16'h0BA9;
        clear_counts();
        send_byte(8'h40);
        wait_idle(100);
        expect_snapshot();
        check("cap_steps", en_cnt, 32'd0);
        compare_bytes("cap");

        // Randomized commands against the model
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 2))
                0: begin
                    do_write(2'($urandom_range(0, 3)), 16'($urandom));
                    @(negedge clk);
                    check_params("rand_write");
                end
                1: begin
                    x = 16'($urandom);
                    y = 16'($urandom);
                    steps = 16'($urandom_range(0, 12));
                    rand_ready = 1'b1;
                    do_run("rand_run", steps);
                    rand_ready = 1'b0;
                end
                default: begin
                    do begin
                        junk = 8'($urandom_range(0, 255));
                    end while (junk[7:2] == 6'b000100 || junk == 8'h20 || junk == 8'h30 ||
                               junk == 8'h40 || junk == 8'h50);
                    clear_counts();
                    send_byte(junk);
                    repeat (3) @(negedge clk);
                    check("junk_busy", busy_cnt, 32'd0);
                    check("junk_load", load_cnt, 32'd0);
                    check("junk_en",   en_cnt, 32'd0);
                end
            endcase
        end

        // Reset in the middle of a 100-step run
        clear_counts();
        send_byte(8'h20);
        send_byte(8'h00);
        send_byte(8'h64);
        n = 0;
        while (en_cnt < 3 && n < 100) begin
            @(negedge clk); #1;
            n++;
        end
        rst = 1'b1;
        reset_model();
        @(negedge clk);
        check("abort_dda_en",   {31'd0, dda_en}, 32'd0);
        check("abort_tx_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("abort_busy",     {31'd0, busy}, 32'd0);
        check_params("abort");
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_steps",    en_cnt, 32'd3);
        check("abort_no_tx",    got_q.size(), 32'd0);
        check("abort_rx_ready", {31'd0, bus.rx_ready}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dda_sequencer.md
DDA_SEQUENCER -- requirements
Module: dda_sequencer

Interface
REQ-001 SHALL have parameter N, default 16, meaning width of state variables and DDA parameters.
REQ-002 SHALL have parameter CW, default 16, meaning step-counter width (CW >= 16).
REQ-003 SHALL have port clk, input, 1, clock; all logic on rising edge.
REQ-004 SHALL have port rst, input, 1, reset: synchronous, active-high.
REQ-005 SHALL have ports rx_valid input 1, rx_data input 8, rx_ready output 1: command byte stream; a byte transfers on a cycle with rx_valid&rx_ready.
REQ-006 SHALL have ports tx_valid output 1, tx_data output 8, tx_ready input 1: result byte stream; a byte transfers on a cycle with tx_valid&tx_ready.
REQ-007 SHALL have ports x, y, input, N each: DDA state variables.
REQ-008 SHALL have ports icx, icy, mu, dt, output, N each: DDA parameter registers.
REQ-009 SHALL have port dda_en, output, 1: DDA step enable, one step per high cycle.
REQ-010 SHALL have port dda_load, output, 1: one-cycle pulse reloading DDA state from icx/icy.
REQ-011 SHALL have port busy, output, 1: high in every state except IDLE.

Function
REQ-012 SHALL implement an FSM with states IDLE, ARG_HI, ARG_LO, RUN, CAPTURE, SEND.
REQ-013 SHALL drive rx_ready high only in IDLE, ARG_HI and ARG_LO; no byte is accepted in any other state.
REQ-014 SHALL decode in IDLE: 0x10..0x13 = write parameter k = low two bits (0 icx, 1 icy, 2 mu, 3 dt), go to ARG_HI; 0x20 = run, go to ARG_HI; 0x30 = pulse dda_load for the following cycle and stay IDLE; 0x40 = go to CAPTURE; any other byte is discarded and the FSM stays IDLE.
REQ-015 SHALL take the argument in ARG_HI (MSB byte) then ARG_LO (LSB byte), forming a 16-bit argument.
REQ-016 SHALL, for write, update the selected parameter register on the ARG_LO transfer cycle; the new value is visible the next cycle; the FSM returns to IDLE.
REQ-017 SHALL, for run, load the step counter with the argument zero-extended to CW and go to RUN if the argument is nonzero, or directly to CAPTURE if it is zero.
REQ-018 SHALL in RUN hold dda_en high for exactly argument consecutive cycles, then go to CAPTURE; dda_en is low in every other state.
REQ-019 SHALL in CAPTURE (one cycle, dda_en low) latch {x, y} into a snapshot register, then go to SEND.
REQ-020 SHALL in SEND emit the bytes x[15:8], x[7:0], y[15:8], y[7:0] in that order, and hold tx_valid and tx_data stable until each byte transfers.
REQ-021 SHALL return to IDLE on the cycle after the fourth byte transfers; tx_valid is low outside SEND.
REQ-022 SHALL keep the snapshot unchanged during SEND regardless of x/y activity.
REQ-023 SHALL keep dda_load low except for the single-cycle pulse of REQ-014.

Reset
REQ-024 SHALL, while rst is high, force: state IDLE; icx=0xC000; icy=0x14CD; mu=0x14DD; dt=0x7240; dda_en=0; dda_load=0; tx_valid=0; tx_data=0; busy=0; step counter=0; snapshot=0.
REQ-025 SHALL abort any partial command, RUN or SEND when rst is asserted mid-operation; no further bytes are emitted after reset.
REQ-026 SHALL drive rx_ready=1 on the first cycle after rst deasserts.

Configuration
REQ-027 SHALL, when macro DDA_SEQ_FREERUN_EN is defined, decode opcode 0x50 in IDLE to toggle a free-run flag (reset 0).
REQ-028 SHALL, while the free-run flag is set and the FSM is in IDLE, hold dda_en high and, whenever no command byte is pending, enter CAPTURE/SEND to stream snapshots continuously.
REQ-029 SHALL, with DDA_SEQ_FREERUN_EN undefined, treat 0x50 as an unrecognized byte and contain no free-run logic.

Verification
REQ-030 SHALL cover: after reset, bytes 0x13,0x12,0x34 -> dt=0x1234 one cycle after the third transfer; icx/icy/mu keep their reset values.
REQ-031 SHALL cover: bytes 0x20,0x00,0x05 with x=0xABCD, y=0x0102 stable -> dda_en high exactly 5 cycles, then tx bytes 0xAB,0xCD,0x01,0x02.
REQ-032 SHALL cover: bytes 0x20,0x00,0x00 -> zero dda_en cycles and an immediate 4-byte snapshot.
REQ-033 SHALL cover: tx_ready held low 10 cycles during SEND -> tx_valid/tx_data stable, rx_ready=0, and no byte is lost or duplicated.
REQ-034 SHALL cover: rst asserted during RUN after 3 of 100 steps -> dda_en=0, tx_valid=0, parameters at reset values the next cycle.
REQ-035 SHALL cover: bytes 0x30 then 0x7F -> a single dda_load pulse, the 0x7F is ignored, and busy remains 0.
